// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
//   RS232 8-bit transmitter: start bit, 8 data bits LSB first, optional parity
//   bit, one stop bit. The bit-period timer, bit counter, shift register and
//   control FSM are all in this block. Bit timing matches the on-chip receiver
//   (BIT_TICKS clocks per bit).
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> PARITY state after DATA, 11-bit frame, parity per PARITY_ODD
//     undefined -> DATA goes straight to STOP, 10-bit frame
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous reset, active-high
//   tx_start_i  in   1  send request, honoured only while busy_o = 0
//   tx_data_i   in   8  byte to send, sampled on the accepting edge only
//   tx_o        out  1  serial line, registered, idles high
//   busy_o      out  1  high from the accepting edge through the done_o cycle
//   done_o      out  1  one-cycle pulse when the frame completes
// -----------------------------------------------------------------------------
module uart_tx_fsm #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int BIT_TICKS  = CLK_FREQ / BAUD_RATE,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] TICK_LAST = CW'(BIT_TICKS - 1);

  // Reject configurations the bit timer cannot support.
  if (BIT_TICKS < 2 || PARITY_ODD > 1'b1) begin : g_param_check
    $error("uart_tx_fsm: BIT_TICKS must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   tick, tick_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [7:0]      shift, shift_next;
  logic            tx_next;
  logic            end_bit;
`ifdef UART_TX_PARITY_EN
  logic            par, par_next;   // running XOR of the bits already sent
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      tx_o    <= tx_next;
`ifdef UART_TX_PARITY_EN
      par     <= par_next;
`endif
    end
  end

  assign end_bit = (tick == TICK_LAST);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    tick_next    = tick + CW'(1);
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
`ifdef UART_TX_PARITY_EN
    par_next     = par;
`endif

    case (state)
      S_IDLE: begin
        tick_next = '0;
        if (tx_start_i) begin
          state_next   = S_START;
          shift_next   = tx_data_i;
          bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
          par_next     = 1'b0;
`endif
        end
      end
      S_START: if (end_bit) state_next = S_DATA;
      S_DATA: begin
        if (end_bit) begin
          shift_next   = shift >> 1;
          bit_cnt_next = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
          par_next     = par ^ shift[0];
          if (bit_cnt == 3'd7) state_next = S_PARITY;
`else
          if (bit_cnt == 3'd7) state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (end_bit) state_next = S_STOP;
`endif
      S_STOP: if (end_bit) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;   // unused encodings recover to IDLE
    endcase

    // The timer restarts at every bit boundary, including DATA-to-DATA.
    if (end_bit || state_next != state) tick_next = '0;

    // tx_o is registered from the next state so the line changes on the
    // same edge as the state it belongs to (start bit low from the
    // accepting edge onward).
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = par_next ^ PARITY_ODD;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);

endmodule
